event_recorder: RTL and testbench

- Synthesizable capture stage that sits directly upstream of the testbench event log.
- Watches two DUT-side conditions and turns each outcome into a timestamped event record:
  - a monitor, which waits for a bit to reach its active level within a cycle budget;
  - a stability checker, which requires a data word to hold while a flag is active.
- Records are buffered in a show-ahead FIFO. The bench drains them with a valid/ready handshake and formats them into log lines.

---
 rtl/event_recorder.sv | 230 +++++++++++++++++++++++
 tb/tb_event_recorder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_recorder.sv
// event_recorder: turns monitor and stability-checker outcomes into
// timestamped records and buffers them in a show-ahead FIFO for a
// valid/ready consumer.
module event_recorder #(
  parameter int   DATA_WIDTH = 8,
  parameter int   TIME_WIDTH = 32,
  parameter int   DEPTH      = 8,
  parameter int   TIMEOUT    = 16,
  parameter logic MON_ACTIVE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mon_arm,
  input  logic                    mon_datum,
  input  logic                    stb_flag,
  input  logic [DATA_WIDTH-1:0]   stb_data,
  input  logic                    evt_ready,
  output logic                    evt_valid,
  output logic [2:0]              evt_level,
  output logic [1:0]              evt_code,
  output logic [TIME_WIDTH-1:0]   evt_time,
  output logic [DATA_WIDTH-1:0]   evt_data,
  output logic [$clog2(DEPTH):0]  evt_count,
  output logic                    overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int FW    = CW + 1;
  localparam int CYW   = $clog2(TIMEOUT + 1);
  localparam int REC_W = 5 + TIME_WIDTH + DATA_WIDTH;

  localparam logic [2:0] LVL_INFO  = 3'd2;
  localparam logic [2:0] LVL_ERROR = 3'd4;
  localparam logic [1:0] CODE_MON  = 2'd0;
  localparam logic [1:0] CODE_STB  = 2'd1;

  localparam logic [63:0] DATA_MAX = (64'd1 << DATA_WIDTH) - 64'd1;

  // Clamp a cycle count into the payload width.
  function automatic logic [DATA_WIDTH-1:0] sat_data(input logic [63:0] v);
    if (v > DATA_MAX) return {DATA_WIDTH{1'b1}};
    return v[DATA_WIDTH-1:0];
  endfunction

  typedef enum logic {MON_IDLE, MON_WAIT} mon_state_e;
  typedef enum logic {STB_IDLE, STB_HOLD} stb_state_e;

  logic [TIME_WIDTH-1:0] ts_q;

  mon_state_e            mon_state_q, mon_state_d;
  logic [CYW-1:0]        cyc_q, cyc_d;
  logic                  mon_push;
  logic [2:0]            mon_lvl;
  logic [DATA_WIDTH-1:0] mon_dat;

  stb_state_e            stb_state_q, stb_state_d;
  logic [DATA_WIDTH-1:0] ref_q, ref_d;
  logic                  err_q, err_d;
  logic                  stb_push;
  logic [2:0]            stb_lvl;
  logic [DATA_WIDTH-1:0] stb_dat;

  logic [REC_W-1:0]      mem [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d, wptr_p1;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [REC_W-1:0]      head_q, head_d;
  logic [REC_W-1:0]      mon_rec, stb_rec, first_rec;
  logic                  pop, acc_mon, acc_stb, first_we, second_we;
  logic [FW-1:0]         free;
  logic [1:0]            n_push;

  // Free-running timestamp, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + TIME_WIDTH'(1);
  end

  // Monitor state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_state_q <= MON_IDLE;
      cyc_q       <= '0;
    end else begin
      mon_state_q <= mon_state_d;
      cyc_q       <= cyc_d;
    end
  end

  // Monitor next state: wait for the active level or give up after TIMEOUT.
  always_comb begin
    mon_state_d = mon_state_q;
    cyc_d       = cyc_q;
    mon_push    = 1'b0;
    mon_lvl     = LVL_INFO;
    mon_dat     = '0;
    case (mon_state_q)
      MON_IDLE: begin
        if (mon_arm) begin
          mon_state_d = MON_WAIT;
          cyc_d       = '0;
        end
      end
      MON_WAIT: begin
        if (mon_datum == MON_ACTIVE) begin
          mon_push    = 1'b1;
          mon_lvl     = LVL_INFO;
          mon_dat     = sat_data(64'(cyc_q));
          mon_state_d = MON_IDLE;
        end else if (cyc_q == CYW'(TIMEOUT)) begin
          mon_push    = 1'b1;
          mon_lvl     = LVL_ERROR;
          mon_dat     = sat_data(64'(TIMEOUT));
          mon_state_d = MON_IDLE;
        end else begin
          cyc_d = cyc_q + CYW'(1);
        end
      end
      default: mon_state_d = MON_IDLE;
    endcase
  end

  // Stability checker state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_state_q <= STB_IDLE;
      ref_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      stb_state_q <= stb_state_d;
      ref_q       <= ref_d;
      err_q       <= err_d;
    end
  end

  // Stability next state: one ERROR per change, INFO at close if clean.
  always_comb begin
    stb_state_d = stb_state_q;
    ref_d       = ref_q;
    err_d       = err_q;
    stb_push    = 1'b0;
    stb_lvl     = LVL_INFO;
    stb_dat     = '0;
    case (stb_state_q)
      STB_IDLE: begin
        if (stb_flag) begin
          ref_d       = stb_data;
          err_d       = 1'b0;
          stb_state_d = STB_HOLD;
        end
      end
      STB_HOLD: begin
        if (!stb_flag) begin
          if (!err_q) begin
            stb_push = 1'b1;
            stb_lvl  = LVL_INFO;
            stb_dat  = ref_q;
          end
          stb_state_d = STB_IDLE;
        end else if (stb_data != ref_q) begin
          stb_push = 1'b1;
          stb_lvl  = LVL_ERROR;
          stb_dat  = stb_data;
          ref_d    = stb_data;
          err_d    = 1'b1;
        end
      end
      default: stb_state_d = STB_IDLE;
    endcase
  end

  assign mon_rec = {mon_lvl, CODE_MON, ts_q, mon_dat};
  assign stb_rec = {stb_lvl, CODE_STB, ts_q, stb_dat};
  assign wptr_p1 = wptr_q + AW'(1);

  // FIFO admission: monitor gets first claim on free slots, then stabilize.
  always_comb begin
    pop       = (count_q != '0) && evt_ready;
    free      = FW'(DEPTH) - {1'b0, count_q} + FW'(pop);
    acc_mon   = mon_push && (free >= FW'(1));
    acc_stb   = stb_push && (free >= (acc_mon ? FW'(2) : FW'(1)));
    ovf_d     = ovf_q | (mon_push & ~acc_mon) | (stb_push & ~acc_stb);
    first_we  = acc_mon | acc_stb;
    second_we = acc_mon & acc_stb;
    first_rec = acc_mon ? mon_rec : stb_rec;
    n_push    = {1'b0, first_we} + {1'b0, second_we};
    count_d   = count_q + CW'(n_push) - CW'(pop);
    wptr_d    = wptr_q + AW'(n_push);
    rptr_d    = rptr_q + AW'(pop);
    head_d    = head_q;
    if (count_d != '0) begin
      if (first_we && (rptr_d == wptr_q))        head_d = first_rec;
      else if (second_we && (rptr_d == wptr_p1)) head_d = stb_rec;
      else                                       head_d = mem[rptr_d];
    end
  end

  // FIFO pointers, occupancy, sticky overflow and the held head record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      head_q  <= head_d;
    end
  end

  // Record storage; the second write slot is used only when both records fit.
  always_ff @(posedge clk) begin
    if (first_we)  mem[wptr_q]  <= first_rec;
    if (second_we) mem[wptr_p1] <= stb_rec;
  end

  assign evt_valid = (count_q != '0);
  assign evt_count = count_q;
  assign overflow  = ovf_q;
  assign evt_level = head_q[REC_W-1 -: 3];
  assign evt_code  = head_q[REC_W-4 -: 2];
  assign evt_time  = head_q[DATA_WIDTH +: TIME_WIDTH];
  assign evt_data  = head_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_event_recorder.sv
// Bench for event_recorder: directed scenarios with literal expectations
// followed by random stimulus against a record-level reference model.
`timescale 1ns/1ps
module tb_event_recorder;
  localparam int DW    = 8;
  localparam int TW    = 32;
  localparam int DEPTH = 8;
  localparam int TO    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_arm = 1'b0, mon_datum = 1'b0, stb_flag = 1'b0, evt_ready = 1'b0;
  logic [DW-1:0] stb_data = '0;
  logic          evt_valid, overflow;
  logic [2:0]    evt_level;
  logic [1:0]    evt_code;
  logic [TW-1:0] evt_time;
  logic [DW-1:0] evt_data;
  logic [CW-1:0] evt_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  event_recorder #(
    .DATA_WIDTH(DW), .TIME_WIDTH(TW), .DEPTH(DEPTH), .TIMEOUT(TO), .MON_ACTIVE(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .mon_arm(mon_arm), .mon_datum(mon_datum),
    .stb_flag(stb_flag), .stb_data(stb_data), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_level(evt_level), .evt_code(evt_code),
    .evt_time(evt_time), .evt_data(evt_data), .evt_count(evt_count),
    .overflow(overflow)
  );

  // ---------------- reference model (record level) ----------------
  typedef struct packed {
    logic [2:0]    lvl;
    logic [1:0]    code;
    logic [TW-1:0] tm;
    logic [DW-1:0] dat;
  } rec_t;

  rec_t          mq[$];
  rec_t          last = '0;
  logic [TW-1:0] m_t = '0;
  bit            m_wait = 1'b0;
  int            m_cyc = 0;
  bit            s_hold = 1'b0, s_err = 1'b0;
  logic [DW-1:0] s_ref = '0;
  bit            m_ovf = 1'b0;

  function automatic rec_t mk(input logic [2:0] l, input logic [1:0] c, input logic [DW-1:0] d);
    rec_t r;
    r.lvl = l; r.code = c; r.tm = m_t; r.dat = d;
    return r;
  endfunction

  task automatic mdl_reset();
    mq.delete();
    last = '0; m_t = '0; m_wait = 1'b0; m_cyc = 0;
    s_hold = 1'b0; s_err = 1'b0; s_ref = '0; m_ovf = 1'b0;
  endtask

  task automatic mdl_step();
    rec_t cand[$];
    if (mq.size() != 0 && evt_ready) void'(mq.pop_front());
    if (m_wait) begin
      if (mon_datum == 1'b1) begin
        cand.push_back(mk(3'd2, 2'd0, DW'((m_cyc > 255) ? 255 : m_cyc)));
        m_wait = 1'b0;
      end else if (m_cyc == TO) begin
        cand.push_back(mk(3'd4, 2'd0, DW'(TO)));
        m_wait = 1'b0;
      end else begin
        m_cyc++;
      end
    end else if (mon_arm) begin
      m_wait = 1'b1;
      m_cyc  = 0;
    end
    if (s_hold) begin
      if (!stb_flag) begin
        if (!s_err) cand.push_back(mk(3'd2, 2'd1, s_ref));
        s_hold = 1'b0;
      end else if (stb_data != s_ref) begin
        cand.push_back(mk(3'd4, 2'd1, stb_data));
        s_ref = stb_data;
        s_err = 1'b1;
      end
    end else if (stb_flag) begin
      s_hold = 1'b1; s_ref = stb_data; s_err = 1'b0;
    end
    foreach (cand[i]) begin
      if (mq.size() < DEPTH) mq.push_back(cand[i]);
      else m_ovf = 1'b1;
    end
    if (mq.size() != 0) last = mq[0];
    m_t = m_t + 1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) mdl_reset();
    else     mdl_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid",    64'(evt_valid), 64'(mq.size() != 0));
      chk("count",    64'(evt_count), 64'(mq.size()));
      chk("overflow", 64'(overflow),  64'(m_ovf));
      chk("level",    64'(evt_level), 64'(last.lvl));
      chk("code",     64'(evt_code),  64'(last.code));
      chk("time",     64'(evt_time),  64'(last.tm));
      chk("data",     64'(evt_data),  64'(last.dat));
    end
  end

  task automatic wait_valid(input int maxc, input string nm);
    int n = 0;
    while (!evt_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_wait_valid"}, 64'(evt_valid), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    evt_ready = 1'b1;
    while (evt_valid && n < 4 * DEPTH) begin
      @(negedge clk);
      n++;
    end
    evt_ready = 1'b0;
    chk("drain_empty", 64'(evt_valid), 64'd0);
  endtask

  task automatic mon_event();
    @(negedge clk); mon_arm = 1'b1;
    @(negedge clk); mon_arm = 1'b0; mon_datum = 1'b1;
    @(negedge clk); mon_datum = 1'b0;
  endtask

  task automatic pair_event(input logic [DW-1:0] d);
    @(negedge clk); mon_arm = 1'b1; stb_flag = 1'b1; stb_data = d;
    @(negedge clk); mon_arm = 1'b0; mon_datum = 1'b1; stb_flag = 1'b0;
    @(negedge clk); mon_datum = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [TW-1:0] a;
    #6;
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_count", 64'(evt_count), 64'd0);
    chk("rst_ovf",   64'(overflow),  64'd0);
    chk("rst_time",  64'(evt_time),  64'd0);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Monitor hit: arm at edge 2, active at edge 6.
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); mon_arm = 1'b1;
    @(negedge clk); mon_arm = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); mon_datum = 1'b1;
    @(negedge clk); mon_datum = 1'b0;
    chk("t1_valid", 64'(evt_valid), 64'd1);
    chk("t1_level", 64'(evt_level), 64'd2);
    chk("t1_code",  64'(evt_code),  64'd0);
    chk("t1_data",  64'(evt_data),  64'd3);
    chk("t1_time",  64'(evt_time),  64'd6);
    drain();

    // Monitor timeout, then immediate re-arm.
    @(negedge clk); a = m_t; mon_arm = 1'b1;
    @(negedge clk); mon_arm = 1'b0;
    wait_valid(40, "t2");
    chk("t2_level", 64'(evt_level), 64'd4);
    chk("t2_data",  64'(evt_data),  64'd16);
    chk("t2_time",  64'(evt_time),  64'(a + 32'd17));
    mon_arm = 1'b1; mon_datum = 1'b1;
    @(negedge clk); mon_arm = 1'b0;
    @(negedge clk); mon_datum = 1'b0;
    chk("t2_rearm_count", 64'(evt_count), 64'd2);
    drain();

    // Stable window of five cycles.
    @(negedge clk); a = m_t; stb_flag = 1'b1; stb_data = 8'hA5;
    repeat (4) @(negedge clk);
    @(negedge clk); stb_flag = 1'b0;
    @(negedge clk);
    chk("t3_level", 64'(evt_level), 64'd2);
    chk("t3_code",  64'(evt_code),  64'd1);
    chk("t3_data",  64'(evt_data),  64'hA5);
    chk("t3_time",  64'(evt_time),  64'(a + 32'd5));
    drain();

    // Unstable window: two errors, no close record.
    @(negedge clk); stb_flag = 1'b1; stb_data = 8'hA5;
    @(negedge clk); stb_data = 8'h3C;
    @(negedge clk); stb_data = 8'h3C;
    @(negedge clk); stb_data = 8'h77;
    @(negedge clk); stb_flag = 1'b0;
    @(negedge clk);
    chk("t4_count", 64'(evt_count), 64'd2);
    chk("t4_level", 64'(evt_level), 64'd4);
    chk("t4_data0", 64'(evt_data),  64'h3C);
    evt_ready = 1'b1;
    @(negedge clk); evt_ready = 1'b0;
    chk("t4_data1", 64'(evt_data),  64'h77);
    drain();

    // Ordering and overflow with the consumer stalled.
    pair_event(8'h11);
    chk("t5_pair_count", 64'(evt_count), 64'd2);
    chk("t5_pair_head",  64'(evt_code),  64'd0);
    for (int i = 0; i < DEPTH - 3; i++) mon_event();
    pair_event(8'h22);
    mon_event();
    chk("t5_full_count", 64'(evt_count), 64'(DEPTH));
    chk("t5_full_ovf",   64'(overflow),  64'd1);
    drain();
    chk("t5_ovf_sticky", 64'(overflow), 64'd1);

    // Asynchronous reset with records queued and both windows open.
    for (int i = 0; i < 3; i++) mon_event();
    @(negedge clk); mon_arm = 1'b1; stb_flag = 1'b1; stb_data = 8'h5A;
    @(negedge clk); mon_arm = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 64'(evt_valid), 64'd0);
    chk("t6_count", 64'(evt_count), 64'd0);
    chk("t6_ovf",   64'(overflow),  64'd0);
    chk("t6_level", 64'(evt_level), 64'd0);
    chk("t6_code",  64'(evt_code),  64'd0);
    chk("t6_time",  64'(evt_time),  64'd0);
    chk("t6_data",  64'(evt_data),  64'd0);
    mon_arm = 1'b1; mon_datum = 1'b1; stb_flag = 1'b0;
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk); mon_arm = 1'b0;
    @(negedge clk); mon_datum = 1'b0;
    chk("t6_post_count", 64'(evt_count), 64'd1);
    chk("t6_post_time",  64'(evt_time),  64'd1);
    chk("t6_post_data",  64'(evt_data),  64'd0);
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      mon_arm   = ($urandom_range(0, 7) == 0);
      mon_datum = ($urandom_range(0, ((i % 1000) < 500) ? 4 : 40) == 0);
      if ($urandom_range(0, 5) == 0) stb_flag = ~stb_flag;
      if ($urandom_range(0, 4) == 0) stb_data = DW'($urandom_range(0, 3) * 8'h55);
      evt_ready = ((i % 400) < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
